// File: rtl/pattern_detector_param_if.sv
`default_nettype none
// ============================================================================
// Module      : pattern_detector_param_if
// Description : Stream, configuration and detection-service bundle for
//               pattern_detector_param. The master side is the stream
//               source / consumer; the slave side is the detector.
//               Optional macro: PD_ACK_TIMEOUT_EN adds ack_timeout.
// Revision    : 1.0 - initial release
// ============================================================================
interface pattern_detector_param_if #(
  parameter int DATA_W  = 8,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 16
);
  logic [PAT_LEN*DATA_W-1:0] cfg_pattern;
  logic [PAT_LEN*DATA_W-1:0] cfg_mask;
  logic                      cfg_overlap;
  logic [DATA_W-1:0]         data;
  logic                      data_valid;
  logic                      data_ready;
  logic                      ack;
  logic                      found_pattern;
  logic [CNT_W-1:0]          match_count;
`ifdef PD_ACK_TIMEOUT_EN
  logic                      ack_timeout;
`endif

  modport master (
    output cfg_pattern, cfg_mask, cfg_overlap, data, data_valid, ack,
    input  data_ready, found_pattern, match_count
`ifdef PD_ACK_TIMEOUT_EN
    , input ack_timeout
`endif
  );

  modport slave (
    input  cfg_pattern, cfg_mask, cfg_overlap, data, data_valid, ack,
    output data_ready, found_pattern, match_count
`ifdef PD_ACK_TIMEOUT_EN
    , output ack_timeout
`endif
  );
endinterface
`default_nettype wire

// File: rtl/pattern_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : pattern_detector_param
// Description : Maskable, runtime-programmable multi-symbol sequence
//               detector on a valid/ready stream. A detection is sticky and
//               stalls the stream until acknowledged. Overlapping or
//               non-overlapping search, saturating match counter.
//               Optional macro: PD_ACK_TIMEOUT_EN (auto-release of HOLD
//               after ACK_TIMEOUT cycles, one-cycle ack_timeout pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_detector_param #(
  parameter int DATA_W  = 8,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 16
`ifdef PD_ACK_TIMEOUT_EN
  , parameter int ACK_TIMEOUT = 255
`endif
) (
  input  logic                    clk,
  input  logic                    reset_sync,
  pattern_detector_param_if.slave bus
);

  localparam int                  c_FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(PAT_LEN);
  localparam int                  c_WIN_W     = PAT_LEN * DATA_W;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    HOLD   = 1'b1
  } state_t;

  state_t               state_q;
  logic [c_WIN_W-1:0]   window_q;
  logic [c_WIN_W-1:0]   window_d;
  logic [c_FILL_W-1:0]  fill_q;
  logic [c_FILL_W-1:0]  fill_d;
  logic                 found_q;
  logic [CNT_W-1:0]     count_q;
  logic                 w_accept;
  logic                 w_match;
  logic [PAT_LEN-1:0]   w_sym_ok;

`ifdef PD_ACK_TIMEOUT_EN
  localparam int              c_TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(ACK_TIMEOUT - 1);
  logic [c_TO_W-1:0] to_cnt_q;
  logic              to_pulse_q;
  assign bus.ack_timeout = to_pulse_q;
`endif

  // Readiness depends on state only, so no path from valid/ack to ready.
  assign bus.data_ready    = (state_q == SEARCH);
  assign bus.found_pattern = found_q;
  assign bus.match_count   = count_q;
  assign w_accept          = bus.data_valid && (state_q == SEARCH);

  // Post-shift window (newest symbol enters the top slot) and saturating fill.
  always_comb begin
    window_d = {bus.data, window_q[c_WIN_W-1:DATA_W]};
    fill_d   = (fill_q == c_FILL_FULL) ? fill_q : fill_q + c_FILL_W'(1);
  end

  // Per-symbol masked compare on the post-shift window.
  generate
    for (genvar k = 0; k < PAT_LEN; k++) begin : g_sym
      assign w_sym_ok[k] = ((window_d[k*DATA_W +: DATA_W] ^ bus.cfg_pattern[k*DATA_W +: DATA_W])
                            & bus.cfg_mask[k*DATA_W +: DATA_W]) == '0;
    end
  endgenerate

  assign w_match = (fill_d == c_FILL_FULL) && (&w_sym_ok);

  // Search/hold control with registered detection flag and counter.
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state_q    <= SEARCH;
      found_q    <= 1'b0;
      count_q    <= '0;
      window_q   <= '0;
      fill_q     <= '0;
`ifdef PD_ACK_TIMEOUT_EN
      to_cnt_q   <= '0;
      to_pulse_q <= 1'b0;
`endif
    end else begin
`ifdef PD_ACK_TIMEOUT_EN
      to_pulse_q <= 1'b0;
`endif
      case (state_q)
        SEARCH: begin
          if (w_accept) begin
            window_q <= window_d;
            fill_q   <= fill_d;
            if (w_match) begin
              state_q <= HOLD;
              found_q <= 1'b1;
              if (count_q != '1) count_q <= count_q + CNT_W'(1);
`ifdef PD_ACK_TIMEOUT_EN
              to_cnt_q <= '0;
`endif
            end
          end
        end
        HOLD: begin
          if (bus.ack) begin
            // Non-overlapping mode demands PAT_LEN fresh symbols.
            state_q <= SEARCH;
            found_q <= 1'b0;
            if (!bus.cfg_overlap) fill_q <= '0;
          end
`ifdef PD_ACK_TIMEOUT_EN
          else if (to_cnt_q == c_TO_LAST) begin
            // Unacknowledged for ACK_TIMEOUT cycles: release as an ack would.
            state_q    <= SEARCH;
            found_q    <= 1'b0;
            to_pulse_q <= 1'b1;
            if (!bus.cfg_overlap) fill_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + c_TO_W'(1);
          end
`endif
        end
        default: begin
          state_q <= SEARCH;
          found_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
